ntt_bfly_pipe: RTL and testbench
================================

NTT_BFLY_PIPE -- requirements
Module: ntt_bfly_pipe

Interface
REQ-001 SHALL have parameter W, default 33: operand/result width in bits.
REQ-002 SHALL have parameter P, default 2^33-2^20+1 (8588886017): odd modulus, P < 2^W.
REQ-003 SHALL have parameter LANES, default 2: independent butterflies processed per beat.
REQ-004 SHALL have parameter MUL_LAT, default 3: modular-multiplier latency in cycles, >= 1.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  input beat offered.
REQ-008 in_ready  out  1  input beat accepted when in_valid&&in_ready.
REQ-009 mode  in  1  0 = forward Cooley-Tukey, 1 = inverse Gentleman-Sande; per beat.
REQ-010 xin, yin, wr  in  LANES*W each  lane-packed operands; lane k at bits [k*W +: W].
REQ-011 out_valid  out  1  output beat present.
REQ-012 out_ready  in  1  downstream accepts output beat.
REQ-013 xout, yout  out  LANES*W each  lane-packed results.
REQ-014 err  out  1  sticky: an accepted operand was >= P.

Function
REQ-015 CT (mode=0), per lane: t = y*w mod P; xout = (x+t) mod P; yout = (x-t) mod P.
REQ-016 GS (mode=1), per lane: xout = (x+y) mod P; yout = ((x-y) mod P)*w mod P.
REQ-017 All results SHALL lie in [0,P-1]; add/sub use W+1-bit intermediates with one conditional correction; products are 2W bits reduced exactly mod P.
REQ-018 Latency SHALL be exactly MUL_LAT+2 cycles from acceptance to out_valid when out_ready stays high.
REQ-019 Throughput SHALL be one beat per cycle with no stall.
REQ-020 mode SHALL travel down the pipeline with its beat; mixed-mode back-to-back beats SHALL be correct.
REQ-021 Stall: when out_valid && !out_ready, every pipeline stage SHALL hold; in_ready = !(out_valid && !out_ready), combinational.
REQ-022 While stalled, xout/yout/out_valid SHALL remain stable until the handshake completes.
REQ-023 Bubbles SHALL propagate as invalid stages; bubbles ahead of a stalled head need not be squeezed.
REQ-024 No beat SHALL be lost or duplicated under any in_valid/out_ready pattern.
REQ-025 err SHALL set the cycle after acceptance of a beat with any xin/yin/wr lane >= P; it stays set until rst; results for that beat are unspecified, timing unaffected.
REQ-026 Lanes SHALL be fully independent; all lanes share valid, mode and stall.

Reset
REQ-027 rst high SHALL, at the next clk edge, clear all stage valid bits, out_valid and err.
REQ-028 xout/yout SHALL reset to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 Data registers other than outputs need not be reset.

Structure
REQ-031 The shared package SHALL hold default P, default W, MODE_CT/MODE_GS constants and the lane-slice width helper.
REQ-032 One sub-module mod_mul (W, P, MUL_LAT, stage enable input) SHALL be instantiated once per lane.
REQ-033 Top level SHALL contain the add/sub stages, valid/mode shift chain, stall logic and err flag.

Verification (P default, LANES=2, MUL_LAT=3)
REQ-034 CT x=5,y=3,w=1024 -> xout=3077, yout=8588882950, out_valid exactly 5 cycles after acceptance.
REQ-035 GS x=5,y=3,w=1024 -> xout=8, yout=2048; next-cycle CT beat on same lanes also correct.
REQ-036 Wrap: CT x=P-1,y=1,w=1 -> xout=0, yout=8588886015; GS x=0,y=1,w=1 -> yout=P-1.
REQ-037 Random 1000 beats, random in_valid/out_ready at 50% -> output stream matches golden model in order, none lost or duplicated, outputs stable while stalled.
REQ-038 xin lane 1 = P on one beat -> err=1 next cycle and held; rst mid-stream with 3 beats in flight -> out_valid=0, err=0 after reset, no stale beat emerges.

Source files
------------

// File: rtl/ntt_bfly_pipe_pkg.sv
// Shared constants and helpers for the NTT butterfly pipeline.
package ntt_bfly_pipe_pkg;

   localparam int unsigned DEF_W = 33;
   // 2^33 - 2^20 + 1
   localparam logic [63:0] DEF_P = 64'd8588886017;

   typedef enum logic {
      MODE_CT = 1'b0,
      MODE_GS = 1'b1
   } mode_e;

   // Bit offset of a lane inside a lane-packed bus.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
      return lane * w;
   endfunction

endpackage

// File: rtl/ntt_bfly_pipe_mod_mul.sv
// Pipelined modular multiplier: p = a*b mod P, MUL_LAT enabled cycles after a/b are presented.
module mod_mul
   import ntt_bfly_pipe_pkg::*;
#(
   parameter int unsigned   W       = DEF_W,
   parameter logic [W-1:0]  P       = W'(DEF_P),
   parameter int unsigned   MUL_LAT = 3
) (
   input  logic         clk,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] p
);

   localparam logic [2*W-1:0] P2 = {{W{1'b0}}, P};

   logic [2*W-1:0] prod;
   assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

   generate
      if (MUL_LAT == 1) begin : g_one
         logic [W-1:0] p_q;
         // Single stage: full product and reduction in one cycle.
         always_ff @(posedge clk) begin
            if (en) p_q <= W'(prod % P2);
         end
         assign p = p_q;
      end else begin : g_multi
         logic [2*W-1:0] prod_q;
         logic [W-1:0]   q [MUL_LAT-1];
         // Product register, then reduction, then plain delay stages to fill the latency.
         always_ff @(posedge clk) begin
            if (en) begin
               prod_q <= prod;
               q[0]   <= W'(prod_q % P2);
               for (int unsigned i = 1; i < MUL_LAT - 1; i++) q[i] <= q[i-1];
            end
         end
         assign p = q[MUL_LAT-2];
      end
   endgenerate

endmodule

// File: rtl/ntt_bfly_pipe.sv
// Multi-lane NTT butterfly: CT (forward) or GS (inverse) per beat, stallable pipeline.
module ntt_bfly_pipe
   import ntt_bfly_pipe_pkg::*;
#(
   parameter int unsigned   W       = DEF_W,
   parameter logic [W-1:0]  P       = W'(DEF_P),
   parameter int unsigned   LANES   = 2,
   parameter int unsigned   MUL_LAT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               mode,
   input  logic [LANES*W-1:0] xin,
   input  logic [LANES*W-1:0] yin,
   input  logic [LANES*W-1:0] wr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] xout,
   output logic [LANES*W-1:0] yout,
   output logic               err
);

   logic               en;
   logic               bad_in;
   logic               v1;
   logic [MUL_LAT-1:0] vd;
   mode_e              m1;
   mode_e              md [MUL_LAT];

   function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, P}) s = s - {1'b0, P};
      return s[W-1:0];
   endfunction

   // A borrow out of the W+1-bit difference means a < b; adding P wraps it back into range.
   function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[W]) d = d + {1'b0, P};
      return d[W-1:0];
   endfunction

   // Whole pipeline advances together unless the output head is blocked.
   assign in_ready = !(out_valid && !out_ready);
   assign en       = in_ready;

   // Flag any lane operand outside [0,P-1].
   always_comb begin
      bad_in = 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (xin[lane_lsb(k, W) +: W] >= P || yin[lane_lsb(k, W) +: W] >= P ||
             wr[lane_lsb(k, W) +: W] >= P)
            bad_in = 1'b1;
      end
   end

   // Valid shift chain: entry stage, multiplier-aligned stages, output.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         vd        <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         v1    <= in_valid;
         vd[0] <= v1;
         for (int unsigned i = 1; i < MUL_LAT; i++) vd[i] <= vd[i-1];
         out_valid <= vd[MUL_LAT-1];
      end
   end

   // Mode travels alongside its beat.
   always_ff @(posedge clk) begin
      if (en) begin
         m1    <= mode_e'(mode);
         md[0] <= m1;
         for (int unsigned i = 1; i < MUL_LAT; i++) md[i] <= md[i-1];
      end
   end

   // Sticky out-of-range operand flag.
   always_ff @(posedge clk) begin
      if (rst) err <= 1'b0;
      else if (in_valid && in_ready && bad_in) err <= 1'b1;
   end

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         localparam int unsigned LSB = lane_lsb(k, W);

         logic [W-1:0] x_i, y_i, w_i;
         logic [W-1:0] a1, mo1, w1, t;
         logic [W-1:0] ad [MUL_LAT];
         logic [W-1:0] xo_q, yo_q;

         assign x_i = xin[LSB +: W];
         assign y_i = yin[LSB +: W];
         assign w_i = wr[LSB +: W];

         // Entry stage: CT forwards x and multiplies y; GS forms the sum and multiplies the difference.
         always_ff @(posedge clk) begin
            if (en) begin
               w1 <= w_i;
               if (mode == MODE_CT) begin
                  a1  <= x_i;
                  mo1 <= y_i;
               end else begin
                  a1  <= mod_add(x_i, y_i);
                  mo1 <= mod_sub(x_i, y_i);
               end
            end
         end

         mod_mul #(
            .W      (W),
            .P      (P),
            .MUL_LAT(MUL_LAT)
         ) u_mul (
            .clk(clk),
            .en (en),
            .a  (mo1),
            .b  (w1),
            .p  (t)
         );

         // Delay the non-multiplied operand to meet the product.
         always_ff @(posedge clk) begin
            if (en) begin
               ad[0] <= a1;
               for (int unsigned i = 1; i < MUL_LAT; i++) ad[i] <= ad[i-1];
            end
         end

         // Output stage: CT finishes the add/sub around t; GS passes sum and product through.
         always_ff @(posedge clk) begin
            if (rst) begin
               xo_q <= '0;
               yo_q <= '0;
            end else if (en) begin
               if (md[MUL_LAT-1] == MODE_CT) begin
                  xo_q <= mod_add(ad[MUL_LAT-1], t);
                  yo_q <= mod_sub(ad[MUL_LAT-1], t);
               end else begin
                  xo_q <= ad[MUL_LAT-1];
                  yo_q <= t;
               end
            end
         end

         assign xout[LSB +: W] = xo_q;
         assign yout[LSB +: W] = yo_q;
      end
   endgenerate

endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// Directed and scoreboarded stress bench for ntt_bfly_pipe (P default, LANES=2, MUL_LAT=3).
module tb_ntt_bfly_pipe;

   localparam int unsigned  W       = 33;
   localparam int unsigned  LANES   = 2;
   localparam int unsigned  MUL_LAT = 3;
   localparam logic [W-1:0] P       = 33'd8588886017;
   localparam logic [67:0]  PX      = 68'd8588886017;
   localparam logic [63:0]  P64     = 64'd8588886017;
   localparam int           NB      = 1000;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               mode;
   logic [LANES*W-1:0] xin, yin, wr;
   logic               out_valid;
   logic               out_ready;
   logic [LANES*W-1:0] xout, yout;
   logic               err;

   ntt_bfly_pipe #(
      .W      (W),
      .P      (P),
      .LANES  (LANES),
      .MUL_LAT(MUL_LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mode     (mode),
      .xin      (xin),
      .yin      (yin),
      .wr       (wr),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .xout     (xout),
      .yout     (yout),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference butterfly on wide integers.
   function automatic void bfly(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] w, output logic [W-1:0] xo, output logic [W-1:0] yo);
      logic [67:0] xx, yy, ww, t, d, r1, r2;
      xx = {35'd0, x};
      yy = {35'd0, y};
      ww = {35'd0, w};
      if (m == 1'b0) begin
         t  = (yy * ww) % PX;
         r1 = (xx + t) % PX;
         r2 = (xx + PX - t) % PX;
      end else begin
         r1 = (xx + yy) % PX;
         d  = (xx + PX - yy) % PX;
         r2 = (d * ww) % PX;
      end
      xo = r1[W-1:0];
      yo = r2[W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(7))
         0:       return '0;
         1:       return P - 1;
         default: return W'(r % P64);
      endcase
   endfunction

   typedef struct packed {
      logic [LANES*W-1:0] x;
      logic [LANES*W-1:0] y;
   } exp_t;

   exp_t               q[$];
   bit                 sb_on = 0;
   bit                 held  = 0;
   logic [LANES*W-1:0] hx, hy;
   int                 n_acc = 0;
   int                 n_rcv = 0;

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (sb_on && !rst) begin
         exp_t e;
         logic [W-1:0] xo, yo;
         check("in_ready", in_ready, !(out_valid && !out_ready));
         if (held) begin
            check("hold_v", out_valid, 1'b1);
            check("hold_x", xout, hx);
            check("hold_y", yout, hy);
         end
         held = out_valid && !out_ready;
         hx   = xout;
         hy   = yout;
         if (in_valid && in_ready) begin
            for (int k = 0; k < int'(LANES); k++) begin
               bfly(mode, xin[k*W +: W], yin[k*W +: W], wr[k*W +: W], xo, yo);
               e.x[k*W +: W] = xo;
               e.y[k*W +: W] = yo;
            end
            q.push_back(e);
            n_acc++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_beat", 1'b1, 1'b0);
            end else begin
               e = q.pop_front();
               check("stream_x", xout, e.x);
               check("stream_y", yout, e.y);
            end
            n_rcv++;
         end
      end
   end

   task automatic drive(input logic m, input logic [W-1:0] x0, input logic [W-1:0] y0, input logic [W-1:0] w0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1, input logic [W-1:0] w1);
      mode     = m;
      xin      = {x1, x0};
      yin      = {y1, y0};
      wr       = {w1, w0};
      in_valid = 1'b1;
   endtask

   task automatic expect_out(input string tag, input logic [W-1:0] ex0, input logic [W-1:0] ey0,
                             input logic [W-1:0] ex1, input logic [W-1:0] ey1);
      check({tag, "_x"}, xout, {ex1, ex0});
      check({tag, "_y"}, yout, {ey1, ey0});
   endtask

   // One beat with out_ready high; called at posedge+1, returns at posedge+1 with the pipe empty.
   task automatic single_beat(input string tag, input logic m,
                              input logic [W-1:0] x0, input logic [W-1:0] y0, input logic [W-1:0] w0,
                              input logic [W-1:0] x1, input logic [W-1:0] y1, input logic [W-1:0] w1,
                              input logic [W-1:0] ex0, input logic [W-1:0] ey0,
                              input logic [W-1:0] ex1, input logic [W-1:0] ey1);
      int n;
      drive(m, x0, y0, w0, x1, y1, w1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, n, 5);
      expect_out(tag, ex0, ey0, ex1, ey1);
      @(posedge clk); #1;
      check({tag, "_once"}, out_valid, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int n;
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mode      = 1'b0;
      xin       = '0;
      yin       = '0;
      wr        = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_xout", xout, '0);
      check("rst_yout", yout, '0);

      // CT basic; lane 1 exercises 2^64 mod P.
      single_beat("ct_basic", 1'b0, 33'd5, 33'd3, 33'd1024, 33'd0, 33'd4294967296, 33'd4294967296,
                  33'd3077, 33'd8588882950, 33'd6474694625, 33'd2114191392);
      // CT wrap-around on both add and subtract paths.
      single_beat("ct_wrap", 1'b0, P - 33'd1, 33'd1, 33'd1, 33'd0, 33'd2, P - 33'd1,
                  33'd0, 33'd8588886015, 33'd8588886015, 33'd2);
      // GS wrap: 0-1 -> P-1; (P-1)+(P-1) -> P-2.
      single_beat("gs_wrap", 1'b1, 33'd0, 33'd1, 33'd1, P - 33'd1, P - 33'd1, 33'd5,
                  33'd1, 33'd8588886016, 33'd8588886015, 33'd0);

      // Back-to-back GS then CT.
      drive(1'b1, 33'd5, 33'd3, 33'd1024, 33'd3, 33'd5, 33'd2);
      @(posedge clk); #1;
      drive(1'b0, 33'd5, 33'd3, 33'd1024, 33'd7, 33'd2, 33'd3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 2;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("mix_lat", n, 5);
      expect_out("mix_gs", 33'd8, 33'd2048, 33'd8, 33'd8588886013);
      @(posedge clk); #1;
      check("mix_ct_v", out_valid, 1'b1);
      expect_out("mix_ct", 33'd3077, 33'd8588882950, 33'd13, 33'd1);
      @(posedge clk); #1;
      check("mix_once", out_valid, 1'b0);

      // Output stall: head held, input blocked, single delivery on release.
      out_ready = 1'b0;
      drive(1'b0, 33'd1, 33'd1, 33'd1, 33'd10, 33'd4, 33'd2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("stall_lat", n, 5);
      check("stall_in_ready", in_ready, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         check("stall_v", out_valid, 1'b1);
         expect_out("stall", 33'd2, 33'd0, 33'd18, 33'd2);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_once", out_valid, 1'b0);

      // Out-of-range operand sets err, then reset with three beats in flight.
      check("err_pre", err, 1'b0);
      drive(1'b0, 33'd1, 33'd1, 33'd1, P, 33'd1, 33'd1);
      @(posedge clk); #1;
      check("err_set", err, 1'b1);
      drive(1'b0, 33'd2, 33'd2, 33'd2, 33'd2, 33'd2, 33'd2);
      @(posedge clk); #1;
      drive(1'b1, 33'd3, 33'd3, 33'd3, 33'd3, 33'd3, 33'd3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("err_held", err, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_valid", out_valid, 1'b0);
      check("rst_mid_err", err, 1'b0);
      check("rst_mid_in_ready", in_ready, 1'b1);
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("no_stale_beat", seen, 0);

      // Random stress against the reference model.
      sb_on = 1;
      for (int c = 0; c < 20000 && n_acc < NB; c++) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom_range(1));
         out_ready = 1'($urandom_range(1));
         mode      = 1'($urandom_range(1));
         xin       = {rnd_op(), rnd_op()};
         yin       = {rnd_op(), rnd_op()};
         wr        = {rnd_op(), rnd_op()};
      end
      in_valid = 1'b0;
      check("rand_accepted", (n_acc >= NB), 1'b1);
      out_ready = 1'b1;
      for (int c = 0; c < 200 && n_rcv < n_acc; c++) @(posedge clk);
      @(posedge clk); #1;
      check("rand_drained", n_rcv, n_acc);
      check("rand_queue_empty", q.size(), 0);
      check("rand_no_err", err, 1'b0);
      sb_on = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
